// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - E-stage pipeline <-> multiply/divide sequencer signal bundle
interface muldiv_ctrl_if;
    logic        valid_e;
    logic [4:0]  alu_control_e;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall_ext;
    logic        flush;
    logic        stall_o;
    logic        result_valid;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    modport master (
        output valid_e, alu_control_e, src_a, src_b, stall_ext, flush,
        input  stall_o, result_valid, hi_o, lo_o, busy
    );

    modport slave (
        input  valid_e, alu_control_e, src_a, src_b, stall_ext, flush,
        output stall_o, result_valid, hi_o, lo_o, busy
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - MIPS E-stage mult/div sequencer (optional early divide: MDU_DIV_EARLY_EN)
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_ctrl_if.slave bus
);
    localparam logic [4:0] ALU_SIGNED_MULT   = 5'd14;
    localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd15;
    localparam logic [4:0] ALU_SIGNED_DIV    = 5'd16;
    localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd17;
    localparam logic [4:0] LAST_MUL          = 5'(MUL_LAT - 1);
    localparam logic [4:0] LAST_DIV          = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic        r_div_zero;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_sgn_op;
    logic        w_accept;
    logic        w_early;
    logic [31:0] w_in_a_mag;
    logic signed [63:0] w_prod;
    logic [31:0] w_b_mag;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_is_mul = (bus.alu_control_e == ALU_SIGNED_MULT) || (bus.alu_control_e == ALU_UNSIGNED_MULT);
    assign w_is_div = (bus.alu_control_e == ALU_SIGNED_DIV)  || (bus.alu_control_e == ALU_UNSIGNED_DIV);
    assign w_sgn_op = (bus.alu_control_e == ALU_SIGNED_MULT) || (bus.alu_control_e == ALU_SIGNED_DIV);

    // Only IDLE accepts, so an instruction parked in E while we finish is never taken twice
    assign w_accept = (r_state == S_IDLE) && bus.valid_e && (w_is_mul || w_is_div) && !bus.flush;

    assign w_in_a_mag = (w_sgn_op && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;

`ifdef MDU_DIV_EARLY_EN
    logic [31:0] w_in_b_mag;
    assign w_in_b_mag = (w_sgn_op && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;
    // Quotient is trivially 0 (or the all-ones divide-by-zero code), skip the iterations
    assign w_early    = w_is_div && ((bus.src_b == 32'd0) || (w_in_a_mag < w_in_b_mag));
`else
    assign w_early    = 1'b0;
`endif

    // Sign-extend to 33 bits so one signed multiply covers both mult and multu
    assign w_prod = $signed({r_signed & r_a[31], r_a}) * $signed({r_signed & r_b[31], r_b});

    // Restoring divide step: shift in the next dividend bit, subtract the divisor if it fits
    assign w_b_mag   = (r_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = (w_shift >= {1'b0, w_b_mag});
    assign w_rem_nxt = w_ge ? (w_shift[31:0] - w_b_mag) : w_shift[31:0];
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    // Quotient negative when operand signs differ; remainder follows the dividend
    assign w_quo_fix = (r_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_quo_nxt) : w_quo_nxt;
    assign w_rem_fix = (r_signed && r_a[31]) ? (32'd0 - w_rem_nxt) : w_rem_nxt;

    // Sequencer FSM: accept, iterate, hold result in DONE until E advances; flush wins everywhere
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_signed   <= 1'b0;
            r_div_zero <= 1'b0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.src_a;
                        r_b        <= bus.src_b;
                        r_signed   <= w_sgn_op;
                        r_div_zero <= (bus.src_b == 32'd0);
                        r_cnt      <= 5'd0;
                        r_rem      <= 32'd0;
                        r_quo      <= w_in_a_mag;
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                        end else if (w_early) begin
                            r_state <= S_DONE;
                            r_hi    <= bus.src_a;
                            r_lo    <= (bus.src_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == LAST_MUL) begin
                        r_state <= S_DONE;
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == LAST_DIV) begin
                            r_state <= S_DONE;
                            if (r_div_zero) begin
                                r_hi <= r_a;
                                r_lo <= 32'hFFFF_FFFF;
                            end else begin
                                r_hi <= w_rem_fix;
                                r_lo <= w_quo_fix;
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.flush || !bus.stall_ext) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_o      = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    assign bus.result_valid = (r_state == S_DONE) && !bus.stall_ext && !bus.flush;
    assign bus.hi_o         = r_hi;
    assign bus.lo_o         = r_lo;
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 2;
    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd14;
    localparam logic [4:0] OP_MULTU = 5'd15;
    localparam logic [4:0] OP_DIV   = 5'd16;
    localparam logic [4:0] OP_DIVU  = 5'd17;
`ifdef MDU_DIV_EARLY_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int n_pushed = 0;
    logic [63:0] sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Every strobe pops one expected {hi,lo}
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (resetn && bus.result_valid) begin
            n_strobe++;
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("hi", {32'd0, bus.hi_o}, {32'd0, e[63:32]});
                check("lo", {32'd0, bus.lo_o}, {32'd0, e[31:0]});
            end
        end
    end

    function automatic int div_stall(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        return (EARLY_EN && (b == 32'd0 || ma < mb)) ? 1 : 33;
    endfunction

    task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
        sb_q.push_back({hi, lo});
        n_pushed++;
    endtask

    task automatic start_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        bus.valid_e       = 1'b1;
        bus.alu_control_e = code;
        bus.src_a         = a;
        bus.src_b         = b;
    endtask

    // Called just after a rising edge; returns just after the edge following the strobe
    task automatic wait_result(input string tag, input int exp_stall);
        int n = 0;
        int guard = 0;
        bit seen = 0;
        while (!seen && guard < 300) begin
            @(negedge clk);
            if (guard == 0) check({tag, "_accept_idle"}, {62'd0, bus.busy, bus.result_valid}, 64'd0);
            if (bus.stall_o) n++;
            if (bus.result_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
            guard++;
        end
        check({tag, "_done"}, {63'd0, seen}, 64'd1);
        check({tag, "_stall"}, n, exp_stall);
        @(posedge clk);
        #1;
        bus.valid_e       = 1'b0;
        bus.alu_control_e = OP_NOP;
    endtask

    task automatic issue(input string tag, input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int exp_stall);
        push_exp(hi, lo);
        start_op(code, a, b);
        wait_result(tag, exp_stall);
    endtask

    initial begin
        logic [31:0] a, b, hi_prev, lo_prev;
        int k, n, guard, strobes_prev, sa, sbv;
        longint sp;
        longint unsigned up;
        bit found;

        bus.valid_e = 0; bus.alu_control_e = OP_NOP; bus.src_a = 0; bus.src_b = 0;
        bus.stall_ext = 0; bus.flush = 0;
        repeat (2) @(negedge clk);
        check("rst_stall", {63'd0, bus.stall_o}, 64'd0);
        check("rst_rv",    {63'd0, bus.result_valid}, 64'd0);
        check("rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("rst_hi",    {32'd0, bus.hi_o}, 64'd0);
        check("rst_lo",    {32'd0, bus.lo_o}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, div_stall(0, 32'd100, 32'd7));
        issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        issue("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT + 1);
        issue("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MUL_LAT + 1);
        issue("divu_z", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, EARLY_EN ? 1 : 33);
        issue("div_z", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, EARLY_EN ? 1 : 33);
        issue("divu_small", OP_DIVU, 32'd5, 32'd9, 32'd5, 32'd0, EARLY_EN ? 1 : 33);

        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 50);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 60);
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            case (k)
                0: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    issue("rnd_mult", OP_MULT, a, b, sp[63:32], sp[31:0], MUL_LAT + 1);
                end
                1: begin
                    up = longint'({32'd0, a}) * longint'({32'd0, b});
                    issue("rnd_multu", OP_MULTU, a, b, up[63:32], up[31:0], MUL_LAT + 1);
                end
                2: begin
                    sa = a; sbv = b;
                    issue("rnd_div", OP_DIV, a, b, 32'(sa % sbv), 32'(sa / sbv), div_stall(1, a, b));
                end
                default: begin
                    issue("rnd_divu", OP_DIVU, a, b, a % b, a / b, div_stall(0, a, b));
                end
            endcase
        end

        // Flush in DIV cycle 10: no strobe, results untouched, next op accepted at once
        hi_prev = bus.hi_o; lo_prev = bus.lo_o; strobes_prev = n_strobe;
        start_op(OP_DIV, 32'd1000, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {63'd0, bus.stall_o}, 64'd1);
        check("flush_rv", {63'd0, bus.result_valid}, 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_idle", {63'd0, bus.busy}, 64'd0);
        check("flush_hi", {32'd0, bus.hi_o}, {32'd0, hi_prev});
        check("flush_lo", {32'd0, bus.lo_o}, {32'd0, lo_prev});
        check("flush_nostrobe", n_strobe, strobes_prev);
        issue("post_flush_multu", OP_MULTU, 32'h0001_0000, 32'h0001_0001, 32'd1, 32'h0001_0000, MUL_LAT + 1);

        // DONE held by stall_ext: strobe only when it drops, instruction not re-taken
        push_exp(32'hFFFF_FFFE, 32'hDCBB_0000);
        bus.stall_ext = 1'b1;
        start_op(OP_MULT, 32'h0001_2345, 32'hFFFF_0000);
        n = 0; guard = 0; found = 0;
        while (!found && guard < 50) begin
            @(negedge clk);
            if (bus.stall_o) n++;
            if (!bus.stall_o && bus.busy) found = 1;
            else begin @(posedge clk); #1; end
            guard++;
        end
        check("hold_done", {63'd0, found}, 64'd1);
        check("hold_stall", n, MUL_LAT + 1);
        for (int i = 0; i < 4; i++) begin
            check("hold_rv", {63'd0, bus.result_valid}, 64'd0);
            check("hold_busy", {62'd0, bus.busy, bus.stall_o}, 64'd2);
            @(posedge clk); #1;
            if (i < 3) @(negedge clk);
        end
        bus.stall_ext = 1'b0;
        @(negedge clk);
        check("hold_strobe", {63'd0, bus.result_valid}, 64'd1);
        @(posedge clk); #1;
        bus.valid_e = 1'b0; bus.alu_control_e = OP_NOP;
        @(negedge clk);
        check("hold_no_reaccept", {62'd0, bus.busy, bus.stall_o}, 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divide
        start_op(OP_DIVU, 32'd777, 32'd5);
        repeat (5) begin @(posedge clk); #1; end
        #2;
        resetn = 1'b0;
        bus.valid_e = 1'b0;
        #1;
        check("arst_busy", {62'd0, bus.busy, bus.stall_o}, 64'd0);
        check("arst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        issue("post_rst_mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT + 1);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("strobe_count", n_strobe, n_pushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
